// File: rtl/onewire_pkg.sv
// Shared types and 1-Wire timing constants for the 1-Wire master core.
// All times are in microseconds of the prescaled time base.
package onewire_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_WAIT,
        SLOT_LOW,
        SLOT_REL,
        SLOT_REC,
        DONE
    } state_e;

    localparam logic OP_RESET = 1'b0;
    localparam logic OP_BYTE  = 1'b1;

    localparam int unsigned US_W = 10;

    localparam logic [US_W-1:0] T_RSTL = 10'd480;
    localparam logic [US_W-1:0] T_PDS  = 10'd70;
    localparam logic [US_W-1:0] T_RSTH = 10'd480;
    localparam logic [US_W-1:0] T_SLOT = 10'd60;
    localparam logic [US_W-1:0] T_LOW1 = 10'd6;
    localparam logic [US_W-1:0] T_LOW0 = 10'd60;
    localparam logic [US_W-1:0] T_SAMP = 10'd15;
    localparam logic [US_W-1:0] T_REC  = 10'd10;

    // Counter value on which the tick completes an interval of t microseconds.
    function automatic logic [US_W-1:0] t_last(input logic [US_W-1:0] t);
        return t - 10'd1;
    endfunction

endpackage

// File: rtl/onewire_master_core_if.sv
// Command/response bundle between a host and the 1-Wire master core.
interface onewire_master_core_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       presence;
    logic       rsp_valid;

    modport master (
        output cmd_valid, cmd_op, tx_data,
        input  cmd_ready, rx_data, presence, rsp_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, tx_data,
        output cmd_ready, rx_data, presence, rsp_valid
    );

endinterface

// File: rtl/onewire_tick.sv
// Microsecond prescaler: one-cycle tick every CDR clocks, restartable so a
// new command starts on a full microsecond.
module onewire_tick #(
    parameter int CDR = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(CDR);
    localparam logic [W-1:0] LAST = W'(CDR - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (clr)          cnt <= '0;
        else if (cnt == LAST)  cnt <= '0;
        else                   cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/onewire_master_core.sv
// 1-Wire bus master: reset/presence cycle or an 8-slot LSB-first byte
// transfer (write 1 slots double as read slots).
module onewire_master_core
    import onewire_pkg::*;
#(
    parameter int CDR = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onewire_master_core_if.slave  bus,
    output logic                  owr_oe,
    input  logic                  owr_i
);

    state_e          state, state_d;
    logic            tick, accept, line, cur_bit;
    logic            us_clr, samp_slot, samp_pres;
    logic            cmd_ready, rsp_valid, pres_q;
    logic [1:0]      sync;
    logic [US_W-1:0] us_cnt, low_last;
    logic [2:0]      idx;
    logic [7:0]      tx_q, rx_shift, rx_q;

    assign accept = bus.cmd_valid && (state == IDLE);

    onewire_tick #(.CDR(CDR)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .tick  (tick)
    );

    // Idle bus level is high, so the synchronizer resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], owr_i};
    end

    assign line     = sync[1];
    assign cur_bit  = tx_q[idx];
    assign low_last = cur_bit ? t_last(T_LOW1) : t_last(T_LOW0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (accept) state_d = bus.cmd_op ? SLOT_LOW : RST_LOW;
            RST_LOW:  if (tick && us_cnt == t_last(T_RSTL)) state_d = RST_WAIT;
            RST_WAIT: if (tick && us_cnt == t_last(T_RSTH)) state_d = DONE;
            // A write-0 low phase already fills the slot, so skip the release phase.
            SLOT_LOW: if (tick && us_cnt == low_last)
                          state_d = (low_last == t_last(T_SLOT)) ? SLOT_REC : SLOT_REL;
            SLOT_REL: if (tick && us_cnt == t_last(T_SLOT)) state_d = SLOT_REC;
            SLOT_REC: if (tick && us_cnt == t_last(T_REC))
                          state_d = (idx == 3'd7) ? DONE : SLOT_LOW;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // The us counter measures from slot start, so it keeps running LOW -> REL.
    assign us_clr    = (state_d != state) && !(state == SLOT_LOW && state_d == SLOT_REL);
    assign samp_slot = tick && (us_cnt == t_last(T_SAMP)) &&
                       (state == SLOT_LOW || state == SLOT_REL);
    assign samp_pres = tick && (us_cnt == t_last(T_PDS)) && (state == RST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt   <= '0;
            idx      <= '0;
            tx_q     <= '0;
            rx_shift <= '0;
            rx_q     <= '0;
            pres_q   <= 1'b0;
        end else begin
            if (us_clr)    us_cnt <= '0;
            else if (tick) us_cnt <= us_cnt + 1'b1;

            if (accept) begin
                idx      <= '0;
                tx_q     <= bus.tx_data;
                rx_shift <= '0;
            end else if (state == SLOT_REC && state_d == SLOT_LOW) begin
                idx <= idx + 1'b1;
            end

            if (samp_slot) rx_shift[idx] <= cur_bit & line;
            if (samp_pres) pres_q <= ~line;
            if (state == SLOT_REC && state_d == DONE) rx_q <= rx_shift;
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        owr_oe    = 1'b0;
        case (state)
            IDLE:              cmd_ready = 1'b1;
            RST_LOW, SLOT_LOW: owr_oe    = 1'b1;
            DONE:              rsp_valid = 1'b1;
            default:           ;
        endcase
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rx_data   = rx_q;
    assign bus.presence  = pres_q;

endmodule

// File: tb/tb_onewire_master_core.sv
// Bench for onewire_master_core: vector table through a scoreboard, plus
// mid-command reset abort and back-to-back command sequences.
module tb_onewire_master_core;

    localparam int CDR = 4;

    typedef struct { logic op; logic [7:0] tx; int mode; logic [7:0] sbyte;
                     logic [7:0] exp_rx; logic exp_pres; } vec_t;
    typedef struct { logic [7:0] rx; logic pres; int unsigned lat; } exp_t;
    typedef struct { int unsigned lat; logic [7:0] rx; logic pres; int unsigned cyc; } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic owr_oe, owr_i;
    logic slave_pull = 1'b0;

    onewire_master_core_if bus();

    onewire_master_core #(.CDR(CDR)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .owr_oe (owr_oe),
        .owr_i  (owr_i)
    );

    always #5 clk = ~clk;

    // Open-drain line with pullup: low if master or slave pulls.
    assign owr_i = ~(owr_oe | slave_pull);

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned pw = 0;
    int unsigned acc_last = 0;
    int unsigned pulses[$];
    int unsigned acc_log[$];
    rsp_t        rsp_q[$];
    rsp_t        rtmp;

    always @(negedge clk) begin
        if (bus.cmd_valid && bus.cmd_ready) begin
            acc_last = cyc;
            acc_log.push_back(cyc);
            pulses.delete();
        end
        if (owr_oe) pw++;
        else if (pw != 0) begin
            pulses.push_back(pw);
            pw = 0;
        end
        if (bus.rsp_valid) begin
            rtmp.lat  = cyc - acc_last;
            rtmp.rx   = bus.rx_data;
            rtmp.pres = bus.presence;
            rtmp.cyc  = cyc;
            rsp_q.push_back(rtmp);
        end
    end

    // Slave: mode 1 answers a reset with presence, mode 2 reads out sbyte.
    int mode = 0;
    logic [7:0] sbyte = 8'h00;
    int sk;
    always begin
        @(posedge owr_oe);
        if (mode == 2) begin
            sk = pulses.size();
            if (sk < 8 && !sbyte[sk]) begin
                slave_pull = 1'b1;
                repeat (30*CDR) @(posedge clk);
                slave_pull = 1'b0;
            end
        end else if (mode == 1) begin
            @(negedge owr_oe);
            repeat (15*CDR) @(posedge clk);
            slave_pull = 1'b1;
            repeat (60*CDR) @(posedge clk);
            slave_pull = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [7:0] m_rx = 8'h00;
    logic m_pres = 1'b0;
    int rsp_expected = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic start_cmd(input logic op, input logic [7:0] tx);
        int a0 = acc_log.size();
        int n = 0;
        bus.cmd_op = op;
        bus.tx_data = tx;
        bus.cmd_valid = 1'b1;
        do begin @(posedge clk); #1; n++; end while (acc_log.size() == a0 && n < 100);
        bus.cmd_valid = 1'b0;
        bus.tx_data = 8'($urandom);
        chk("accept", 32'(acc_log.size() != a0), 1);
    endtask

    task automatic wait_rsp(input int r0, input int budget);
        int n = 0;
        while (rsp_q.size() <= r0 && n < budget) begin @(posedge clk); #1; n++; end
        chk("rsp_seen", 32'(rsp_q.size() > r0), 1);
    endtask

    task automatic compare(input exp_t e, input int r);
        if (r < rsp_q.size()) begin
            chk("latency",  rsp_q[r].lat,  e.lat);
            chk("rx_data",  rsp_q[r].rx,   e.rx);
            chk("presence", rsp_q[r].pres, e.pres);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int r0 = rsp_q.size();
        int n_exp = v.op ? 8 : 1;
        mode = v.mode;
        sbyte = v.sbyte;
        if (v.op) m_rx = v.exp_rx; else m_pres = v.exp_pres;
        e.rx = m_rx;
        e.pres = m_pres;
        e.lat = (v.op ? 560 : 960) * CDR + 1;
        exp_q.push_back(e);
        rsp_expected++;
        start_cmd(v.op, v.tx);
        wait_rsp(r0, 1100*CDR);
        compare(exp_q.pop_front(), r0);
        repeat (2) @(posedge clk);
        #1;
        chk("pulse_cnt", pulses.size(), n_exp);
        for (int i = 0; i < n_exp && i < pulses.size(); i++)
            chk("pulse_w", pulses[i], (v.op ? (v.tx[i] ? 6 : 60) : 480) * CDR);
        chk("ready_after", bus.cmd_ready, 1);
    endtask

    vec_t vecs[7];

    initial begin
        exp_t e;
        int r0, a0, n;
        vecs[0] = '{1'b0, 8'h00, 1, 8'h00, 8'h00, 1'b1};
        vecs[1] = '{1'b1, 8'h55, 0, 8'h00, 8'h55, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 0, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 8'hFF, 2, 8'hA3, 8'hA3, 1'b0};
        vecs[4] = '{1'b1, 8'h00, 2, 8'hFF, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{1'b1, 8'hFF, 0, 8'h00, 8'hFF, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op = 1'b0;
        bus.tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_oe",    owr_oe, 0);
        chk("rst_rsp",   bus.rsp_valid, 0);
        chk("rst_rx",    bus.rx_data, 8'h00);
        chk("rst_pres",  bus.presence, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset during slot 3 of a write-0 byte: line released at once, no response.
        mode = 0;
        r0 = rsp_q.size();
        start_cmd(1'b1, 8'h00);
        repeat (230*CDR) @(posedge clk);
        #1;
        chk("abort_pre_oe", owr_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_oe",  owr_oe, 0);
        chk("abort_rsp", bus.rsp_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (600*CDR) @(posedge clk);
        #1;
        chk("abort_no_rsp", rsp_q.size(), r0);
        chk("abort_ready",  bus.cmd_ready, 1);
        chk("abort_rx",     bus.rx_data, 8'h00);
        chk("abort_pres",   bus.presence, 0);
        m_rx = 8'h00;
        m_pres = 1'b0;

        // cmd_valid held through a busy command: second accept right after rsp.
        mode = 0;
        r0 = rsp_q.size();
        a0 = acc_log.size();
        e.rx = m_rx;
        e.pres = 1'b0;
        e.lat = 960*CDR + 1;
        exp_q.push_back(e);
        exp_q.push_back(e);
        rsp_expected += 2;
        bus.cmd_op = 1'b0;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (acc_log.size() < a0 + 2 && n < 2200*CDR) begin @(posedge clk); #1; n++; end
        bus.cmd_valid = 1'b0;
        chk("held_accepts", acc_log.size() - a0, 2);
        wait_rsp(r0 + 1, 1100*CDR);
        compare(exp_q.pop_front(), r0);
        compare(exp_q.pop_front(), r0 + 1);
        if (acc_log.size() >= a0 + 2 && rsp_q.size() > r0)
            chk("reaccept_gap", acc_log[a0+1] - rsp_q[r0].cyc, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("held_accepts_final", acc_log.size() - a0, 2);
        chk("total_rsp", rsp_q.size(), rsp_expected);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
